// File: rtl/vga_square_anim.sv
// 640x480@60Hz VGA timing generator plus a bouncing square that moves one pixel diagonally per frame.
// Timing outputs are combinational decodes of the h/v registers; the square updates once per frame.
// No backpressure: everything advances only on cycles where i_pix_stb is high and holds otherwise.
module vga_square_anim #(
    parameter int H_SIZE   = 60,
    parameter int IX       = 160,
    parameter int IY       = 120,
    parameter int IX_DIR   = 1,
    parameter int IY_DIR   = 1,
    parameter int D_WIDTH  = 640,
    parameter int D_HEIGHT = 480
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_pix_stb,
    output logic        o_hs,
    output logic        o_vs,
    output logic [9:0]  o_x,
    output logic [8:0]  o_y,
    output logic        o_active,
    output logic        o_blanking,
    output logic        o_screenend,
    output logic        o_animate,
    output logic [11:0] o_x1,
    output logic [11:0] o_x2,
    output logic [11:0] o_y1,
    output logic [11:0] o_y2,
    output logic        o_in_square
);

    // Horizontal timing: front porch 0..15, sync 16..111, back porch 112..159, active 160..799.
    localparam logic [9:0] HS_STA   = 10'd16;
    localparam logic [9:0] HS_END   = 10'd112;
    localparam logic [9:0] HA_STA   = 10'd160;
    localparam logic [9:0] LINE_END = 10'd799;

    // Vertical timing: active 0..479, front porch 480..489, sync 490..491, back porch 492..524.
    localparam logic [9:0] VA_END   = 10'd480;
    localparam logic [9:0] VS_STA   = 10'd490;
    localparam logic [9:0] VS_END   = 10'd492;
    localparam logic [9:0] VA_LAST  = 10'd479;
    localparam logic [9:0] SCR_END  = 10'd524;

    // Bounce limits on the square centre, and its half-width at register width.
    localparam logic [11:0] HALF   = 12'(H_SIZE);
    localparam logic [11:0] X_LO   = 12'(H_SIZE + 1);
    localparam logic [11:0] X_HI   = 12'(D_WIDTH - (H_SIZE + 1));
    localparam logic [11:0] Y_LO   = 12'(H_SIZE + 1);
    localparam logic [11:0] Y_HI   = 12'(D_HEIGHT - (H_SIZE + 1));
    localparam logic [11:0] X_INIT = 12'(IX);
    localparam logic [11:0] Y_INIT = 12'(IY);
    localparam logic        XD_INIT = (IX_DIR != 0);
    localparam logic        YD_INIT = (IY_DIR != 0);

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic [11:0] x_pos;
    logic [11:0] y_pos;
    logic        x_dir;
    logic        y_dir;
    logic        anim_step;
    logic [11:0] px_ext;
    logic [11:0] py_ext;

    // Raster position counters: h wraps at end of line and carries into v, v wraps at end of screen.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else if (i_pix_stb) begin
            if (h_cnt == LINE_END) begin
                h_cnt <= 10'd0;
                if (v_cnt == SCR_END) begin
                    v_cnt <= 10'd0;
                end else begin
                    v_cnt <= v_cnt + 10'd1;
                end
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Sync pulses, visible-area flag and pixel coordinates decoded from the raster counters.
    always_comb begin
        o_hs       = ~((h_cnt >= HS_STA) && (h_cnt < HS_END));
        o_vs       = ~((v_cnt >= VS_STA) && (v_cnt < VS_END));
        o_active   = (h_cnt >= HA_STA) && (v_cnt < VA_END);
        o_blanking = ~o_active;
        o_x        = (h_cnt < HA_STA) ? 10'd0 : (h_cnt - HA_STA);
        // y saturates at the last visible line through vertical blanking
        o_y        = (v_cnt >= VA_END) ? 9'd479 : v_cnt[8:0];
    end

    // Frame markers: animate at the last visible pixel, screenend at the last pixel of the frame.
    always_comb begin
        o_animate   = (h_cnt == LINE_END) && (v_cnt == VA_LAST);
        o_screenend = (h_cnt == LINE_END) && (v_cnt == SCR_END);
        anim_step   = o_animate && i_pix_stb;
    end

    // Square centre and direction: the move uses the current direction, while the new direction
    // is chosen from the pre-move centre, so the square overshoots the limit by one pixel.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            x_pos <= X_INIT;
            y_pos <= Y_INIT;
            x_dir <= XD_INIT;
            y_dir <= YD_INIT;
        end else if (anim_step) begin
            x_pos <= x_dir ? (x_pos + 12'd1) : (x_pos - 12'd1);
            y_pos <= y_dir ? (y_pos + 12'd1) : (y_pos - 12'd1);
            if (x_pos <= X_LO) begin
                x_dir <= 1'b1;
            end else if (x_pos >= X_HI) begin
                x_dir <= 1'b0;
            end
            if (y_pos <= Y_LO) begin
                y_dir <= 1'b1;
            end else if (y_pos >= Y_HI) begin
                y_dir <= 1'b0;
            end
        end
    end

    // Bounding box and the in-square flag used by the downstream colour logic.
    always_comb begin
        o_x1        = x_pos - HALF;
        o_x2        = x_pos + HALF;
        o_y1        = y_pos - HALF;
        o_y2        = y_pos + HALF;
        px_ext      = {2'b00, o_x};
        py_ext      = {3'b000, o_y};
        o_in_square = o_active
                    && (px_ext >= o_x1) && (px_ext < o_x2)
                    && (py_ext >= o_y1) && (py_ext < o_y2);
    end

endmodule

// File: tb/tb_vga_square_anim.sv
// Bench for vga_square_anim: directed phases with random strobe gaps, checked against a raster/square model.
// Model derives h/v from a strobe count and moves the square with the bounce rules.
// Animation is reached by pinning the raster at the end of active drawing.
module tb_vga_square_anim;

    logic        clk;
    logic        rst_n;
    logic        pix_stb;
    logic        hs;
    logic        vs;
    logic [9:0]  px;
    logic [8:0]  py;
    logic        active;
    logic        blanking;
    logic        screenend;
    logic        animate;
    logic [11:0] x1;
    logic [11:0] x2;
    logic [11:0] y1;
    logic [11:0] y2;
    logic        in_square;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // model state: strobes since reset, square centre and direction
    int n_stb;
    int sq_x;
    int sq_y;
    int sq_dx;
    int sq_dy;

    vga_square_anim dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_pix_stb   (pix_stb),
        .o_hs        (hs),
        .o_vs        (vs),
        .o_x         (px),
        .o_y         (py),
        .o_active    (active),
        .o_blanking  (blanking),
        .o_screenend (screenend),
        .o_animate   (animate),
        .o_x1        (x1),
        .o_x2        (x2),
        .o_y1        (y1),
        .o_y2        (y2),
        .o_in_square (in_square)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0d want %0d (strobe %0d)", tag, got, want, n_stb);
        end
    endtask

    task automatic model_reset();
        n_stb = 0;
        sq_x  = 160;
        sq_y  = 120;
        sq_dx = 1;
        sq_dy = 1;
    endtask

    // one frame's move: step with the current heading, then re-aim from the old centre
    task automatic model_move();
        int nx;
        int ny;
        nx = (sq_dx != 0) ? sq_x + 1 : sq_x - 1;
        ny = (sq_dy != 0) ? sq_y + 1 : sq_y - 1;
        if (sq_x <= 61) sq_dx = 1;
        else if (sq_x >= 640 - 61) sq_dx = 0;
        if (sq_y <= 61) sq_dy = 1;
        else if (sq_y >= 480 - 61) sq_dy = 0;
        sq_x = nx;
        sq_y = ny;
    endtask

    task automatic check_square();
        chk("x1", x1, 32'(sq_x - 60));
        chk("x2", x2, 32'(sq_x + 60));
        chk("y1", y1, 32'(sq_y - 60));
        chk("y2", y2, 32'(sq_y + 60));
    endtask

    task automatic check_pixel(input int hh, input int vv);
        int  ex;
        int  ey;
        logic ea;
        logic ein;
        ex  = (hh < 160) ? 0 : hh - 160;
        ey  = (vv >= 480) ? 479 : vv;
        ea  = (hh >= 160) && (vv < 480);
        ein = ea && (ex >= sq_x - 60) && (ex < sq_x + 60) && (ey >= sq_y - 60) && (ey < sq_y + 60);
        chk("hs", hs, 32'(!(hh >= 16 && hh < 112)));
        chk("vs", vs, 32'(!(vv >= 490 && vv < 492)));
        chk("x", px, 32'(ex));
        chk("y", py, 32'(ey));
        chk("active", active, 32'(ea));
        chk("blanking", blanking, 32'(!ea));
        chk("screenend", screenend, 32'(hh == 799 && vv == 524));
        chk("animate", animate, 32'(hh == 799 && vv == 479));
        chk("in_square", in_square, 32'(ein));
    endtask

    task automatic check_all();
        check_pixel(n_stb % 800, (n_stb / 800) % 525);
    endtask

    // one clock with the given strobe; outputs are sampled 1 time unit after the edge
    task automatic tick(input logic s);
        int hh;
        int vv;
        hh = n_stb % 800;
        vv = (n_stb / 800) % 525;
        pix_stb = s;
        @(posedge clk);
        #1;
        if (s) begin
            if (hh == 799 && vv == 479) model_move();
            n_stb = n_stb + 1;
        end
        check_all();
    endtask

    initial begin
        int extra;
        rst_n   = 1'b0;
        pix_stb = 1'b0;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_all();
        check_square();
        chk("x1_reset", x1, 32'd100);
        chk("x2_reset", x2, 32'd220);
        chk("y1_reset", y1, 32'd60);
        chk("y2_reset", y2, 32'd180);
        rst_n = 1'b1;

        // first line with a strobe every 4th clock
        for (int i = 0; i < 800; i++) begin
            tick(1'b1);
            tick(1'b0);
            tick(1'b0);
            tick(1'b0);
        end
        chk("line_wrap_x", px, 32'd0);
        chk("line_wrap_y", py, 32'd1);

        // random strobe gaps down to line 60, mid-line, crossing the square's top-left corner
        while (n_stb < 60 * 800 + 400) begin
            if ($urandom_range(0, 15) == 0) begin
                repeat ($urandom_range(1, 2)) tick(1'b0);
            end
            tick(1'b1);
        end

        // strobe held low mid-line: nothing moves
        repeat (100) tick(1'b0);
        chk("hold_x", px, 32'd240);
        chk("hold_y", py, 32'd60);

        // pin the raster at end of active drawing so every strobe is a frame update
        pix_stb = 1'b0;
        force dut.h_cnt = 10'd799;
        force dut.v_cnt = 10'd479;
        #1;
        chk("pinned_animate", animate, 32'd1);
        chk("pinned_screenend", screenend, 32'd0);
        extra = int'($urandom_range(0, 600));
        for (int f = 1; f <= 421 + extra; f++) begin
            pix_stb = 1'b1;
            @(posedge clk);
            #1;
            model_move();
            check_square();
            check_pixel(799, 479);
            if (f == 1) begin
                chk("x1_first", x1, 32'd101);
                chk("x2_first", x2, 32'd221);
                chk("y1_first", y1, 32'd61);
                chk("y2_first", y2, 32'd181);
            end
            if (f == 419) chk("x1_f419", x1, 32'd519);
            if (f == 420) chk("x1_f420", x1, 32'd520);
            if (f == 421) chk("x1_f421", x1, 32'd519);
        end
        pix_stb = 1'b0;
        release dut.h_cnt;
        release dut.v_cnt;

        // asynchronous reset between clock edges restores raster and square at once
        #1;
        rst_n = 1'b0;
        model_reset();
        #2;
        check_all();
        check_square();
        chk("x1_rst2", x1, 32'd100);
        chk("y1_rst2", y1, 32'd60);
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // random traffic after restart
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 7) == 0) tick(1'b0);
            tick(1'b1);
        end
        check_square();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
